// File: rtl/noise_lfsr_bank.sv
// -----------------------------------------------------------------------------
// noise_lfsr_bank
//
// Multi-channel pseudo-random noise source. Every channel owns a 32-bit LFSR,
// a rate divider, a period mode and an enable. The low WIDTH bits of each
// LFSR are presented on `out`. A registered sum of the low bytes of all
// enabled channels is presented on `mix`.
//
// Parameters
//   WIDTH    : per-channel output word width (8..32)
//   CHANNELS : number of channels (1..8)
//   DIV_W    : width of the per-channel rate divider
//   CW       : width of the channel address, max(1, clog2(CHANNELS))
//   MW       : width of the mix sum, 8 + CW
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   en       : global run enable; low freezes every divider and LFSR
//   cfg_we   : one-cycle configuration write strobe
//   cfg_ch   : channel addressed by the write (out-of-range writes ignored)
//   cfg_en   : channel enable loaded by the write
//   cfg_mode : 0 = long 32-bit Galois LFSR, 1 = short 7-bit Fibonacci LFSR
//   cfg_div  : channel steps once every cfg_div+1 active cycles
//   cfg_seed : LFSR seed, sanitised so that the LFSR can never lock up
//   out      : channel c at [c*WIDTH +: WIDTH] = state_c[WIDTH-1:0]
//   step     : per-channel pulse, high in the cycle after that LFSR advanced
//   mix      : registered sum of out_c[7:0] over enabled channels
//
// Interface protocol: there is no valid/ready handshake in this block. The
// configuration port is a fire-and-forget strobe: whenever cfg_we is high at
// a rising edge the addressed channel is rewritten on that edge, and the
// write always wins over a step that would have happened on the same edge.
// -----------------------------------------------------------------------------
module noise_lfsr_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 16,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int MW      = 8 + CW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_we,
  input  logic [CW-1:0]             cfg_ch,
  input  logic                      cfg_en,
  input  logic                      cfg_mode,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [31:0]               cfg_seed,
  output logic [CHANNELS*WIDTH-1:0] out,
  output logic [CHANNELS-1:0]       step,
  output logic [MW-1:0]             mix
);

  // Galois taps for the long mode (x^32 + x^22 + x^2 + x + 1, right shift).
  localparam logic [31:0] LONG_TAPS = 32'h8020_0003;

  // ---------------------------------------------------------------------------
  // LFSR next-state. The short mode keeps bits [31:7] at zero so that the
  // output word of a short channel only ever shows the 7-bit sequence.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] lfsr_next(input logic [31:0] s,
                                            input logic        short_mode);
    logic [31:0] n;
    logic        fb;
    if (short_mode) begin
      fb = s[6] ^ s[5];
      n  = {25'b0, s[5:0], fb};
    end else if (s[0]) begin
      n = (s >> 1) ^ LONG_TAPS;
    end else begin
      n = s >> 1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Seed sanitising. An all-zero state is the lock-up state of both LFSRs, so
  // a zero seed (only the low 7 bits count in short mode) is replaced by 1.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] seed_load(input logic [31:0] seed,
                                            input logic        short_mode);
    logic [31:0] v;
    if (short_mode) begin
      v = {25'b0, seed[6:0]};
      if (seed[6:0] == 7'd0) begin
        v = 32'h0000_0001;
      end
    end else begin
      v = seed;
      if (seed == 32'd0) begin
        v = 32'h0000_0001;
      end
    end
    return v;
  endfunction

  // The sanitised seed is the same for whichever channel is addressed, so it
  // is computed once and shared.
  logic [31:0] seed_val;
  assign seed_val = seed_load(cfg_seed, cfg_mode);

  // Per-channel views used by the mix adder.
  logic [7:0]          low_byte [CHANNELS];
  logic [CHANNELS-1:0] ch_en_vec;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [31:0]      state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic             mode_q;
    logic             ch_en_q;
    logic             step_q;

    logic wr_hit;   // this channel is addressed by a write on this edge
    logic active;   // divider runs this cycle
    logic due;      // divider has reached its terminal count

    // cfg_ch values >= CHANNELS never match any channel, so such writes are
    // dropped without extra logic.
    assign wr_hit = cfg_we && (cfg_ch == CW'(c));
    assign active = en && ch_en_q;
    // cnt counts 0..div inclusive; with div all-ones this spans 2^DIV_W
    // cycles and cnt never wraps because it is cleared on the match.
    assign due    = (cnt_q == div_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= 32'(c + 1);
        cnt_q   <= '0;
        div_q   <= '0;
        mode_q  <= 1'b0;
        ch_en_q <= 1'b0;
        step_q  <= 1'b0;
      end else if (wr_hit) begin
        // A write replaces whatever step would have happened on this edge.
        ch_en_q <= cfg_en;
        mode_q  <= cfg_mode;
        div_q   <= cfg_div;
        cnt_q   <= '0;
        state_q <= seed_val;
        step_q  <= 1'b0;
      end else if (active) begin
        if (due) begin
          state_q <= lfsr_next(state_q, mode_q);
          cnt_q   <= '0;
          step_q  <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + DIV_W'(1);
          step_q  <= 1'b0;
        end
      end else begin
        // Inactive: state and count hold, no pulse.
        step_q <= 1'b0;
      end
    end

    // out is a direct view of the state register, so it changes on the same
    // edge that raises step.
    assign out[c*WIDTH +: WIDTH] = state_q[WIDTH-1:0];
    assign step[c]               = step_q;
    assign low_byte[c]           = state_q[7:0];
    assign ch_en_vec[c]          = ch_en_q;
  end : g_ch

  // ---------------------------------------------------------------------------
  // Mix: sum of the current low bytes of enabled channels, registered once,
  // so mix lags out by exactly one cycle. MW bits hold 255*CHANNELS exactly.
  // ---------------------------------------------------------------------------
  logic [MW-1:0] mix_sum;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_en_vec[i]) begin
        mix_sum = mix_sum + MW'(low_byte[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix <= '0;
    end else begin
      mix <= mix_sum;
    end
  end

endmodule : noise_lfsr_bank

// File: tb/tb_noise_lfsr_bank.sv
// -----------------------------------------------------------------------------
// tb_noise_lfsr_bank
//
// Bench for noise_lfsr_bank. A 4-channel instance is the main DUT; a
// 3-channel instance shares every input so that cfg_ch = 3 is an
// out-of-range address for it. A cycle model predicts out/step/mix of both
// instances; predictions are queued when inputs are driven and compared
// after the following rising edge. Known sequences are also checked against
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_noise_lfsr_bank;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic        cfg_en;
  logic        cfg_mode;
  logic [15:0] cfg_div;
  logic [31:0] cfg_seed;

  logic [127:0] out;
  logic [3:0]   step;
  logic [9:0]   mix;
  logic [95:0]  out3;
  logic [2:0]   step3;
  logic [9:0]   mix3;

  noise_lfsr_bank #(.WIDTH(32), .CHANNELS(4), .DIV_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .cfg_seed(cfg_seed), .out(out), .step(step), .mix(mix)
  );

  noise_lfsr_bank #(.WIDTH(32), .CHANNELS(3), .DIV_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_div(cfg_div),
    .cfg_seed(cfg_seed), .out(out3), .step(step3), .mix(mix3)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [141:0] exp_q[$];   // {out, step, mix} of the 4-channel instance
  logic [108:0] exp3_q[$];  // {out3, step3, mix3} of the 3-channel instance

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [31:0] m_state [4];
  logic [15:0] m_cnt   [4];
  logic [15:0] m_div   [4];
  logic [3:0]  m_mode;
  logic [3:0]  m_chen;
  logic [3:0]  m_step;
  logic [9:0]  m_mix;
  logic [9:0]  m_mix3;

  function automatic logic [31:0] ref_adv(input logic [31:0] s, input logic m);
    logic [31:0] r;
    if (m) begin
      r = 32'd0;
      r[6:1] = s[5:0];
      r[0]   = s[6] ^ s[5];
    end else begin
      r = {1'b0, s[31:1]};
      if (s[0]) r = r ^ 32'h8020_0003;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_seed(input logic [31:0] s, input logic m);
    logic [31:0] r;
    r = m ? (s & 32'h7F) : s;
    if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_state[c] = 32'(c + 1);
      m_cnt[c]   = 16'd0;
      m_div[c]   = 16'd0;
    end
    m_mode = '0;
    m_chen = '0;
    m_step = '0;
    m_mix  = '0;
    m_mix3 = '0;
  endtask

  // Advance the model by one edge using the inputs currently driven, then
  // queue the prediction for that edge.
  task automatic model_tick();
    logic [9:0]   s4;
    logic [9:0]   s3;
    logic [127:0] o;
    s4 = '0;
    s3 = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_chen[c]) begin
        s4 = s4 + 10'(m_state[c][7:0]);
        if (c < 3) s3 = s3 + 10'(m_state[c][7:0]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (cfg_we && cfg_ch == 2'(c)) begin
        m_chen[c]  = cfg_en;
        m_mode[c]  = cfg_mode;
        m_div[c]   = cfg_div;
        m_cnt[c]   = 16'd0;
        m_state[c] = ref_seed(cfg_seed, cfg_mode);
        m_step[c]  = 1'b0;
      end else if (en && m_chen[c]) begin
        if (m_cnt[c] == m_div[c]) begin
          m_state[c] = ref_adv(m_state[c], m_mode[c]);
          m_cnt[c]   = 16'd0;
          m_step[c]  = 1'b1;
        end else begin
          m_cnt[c]  = m_cnt[c] + 16'd1;
          m_step[c] = 1'b0;
        end
      end else begin
        m_step[c] = 1'b0;
      end
    end
    m_mix  = s4;
    m_mix3 = s3;
    for (int c = 0; c < 4; c++) o[c*32 +: 32] = m_state[c];
    exp_q.push_back({o, m_step, m_mix});
    exp3_q.push_back({o[95:0], m_step[2:0], m_mix3});
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock edge: predict, let the edge happen, compare 1 ns later.
  task automatic tick();
    logic [141:0] e4;
    logic [108:0] e3;
    model_tick();
    @(posedge clk);
    #1;
    e4 = exp_q.pop_front();
    e3 = exp3_q.pop_front();
    check("sb_ch4", {out, step, mix}, e4);
    check("sb_ch3", {out3, step3, mix3}, e3);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic ce,
                           input logic md, input logic [15:0] dv,
                           input logic [31:0] sd);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_en   = ce;
    cfg_mode = md;
    cfg_div  = dv;
    cfg_seed = sd;
    tick();
    cfg_we   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: seed sanitising and single-step results on channel 0
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        mode;
    logic [31:0] seed;
    logic [31:0] exp_load;
    logic [31:0] exp_step;
  } vec_t;

  vec_t vecs [11];
  logic [31:0] short_seq [6];

  initial begin
    int   act;
    logic exp_bit;
    logic early;

    vecs[0]  = '{1'b0, 32'h0000_0001, 32'h0000_0001, 32'h8020_0003};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0001, 32'h8020_0003};
    vecs[2]  = '{1'b0, 32'h0000_0002, 32'h0000_0002, 32'h0000_0001};
    vecs[3]  = '{1'b0, 32'h8020_0003, 32'h8020_0003, 32'hC030_0002};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFDF_FFFC};
    vecs[5]  = '{1'b1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002};
    vecs[7]  = '{1'b1, 32'hFFFF_FF80, 32'h0000_0001, 32'h0000_0002};
    vecs[8]  = '{1'b1, 32'h0000_0060, 32'h0000_0060, 32'h0000_0040};
    vecs[9]  = '{1'b1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0001};
    vecs[10] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_007F, 32'h0000_007E};
    short_seq = '{32'h02, 32'h04, 32'h08, 32'h10, 32'h20, 32'h41};

    // ---- reset -------------------------------------------------------------
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
    cfg_mode = 1'b0; cfg_div = '0; cfg_seed = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out",  out,  {32'd4, 32'd3, 32'd2, 32'd1});
    check("reset_step", step, 4'd0);
    check("reset_mix",  mix,  10'd0);
    check("reset_out3", out3, {32'd3, 32'd2, 32'd1});
    check("reset_mix3", mix3, 10'd0);

    // ---- table: load value then one step, ch0 div 0 ------------------------
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cfg_write(2'd0, 1'b1, vecs[i].mode, 16'd0, vecs[i].seed);
      check("vec_load",       out[31:0], vecs[i].exp_load);
      check("vec_load_step0", step[0],   1'b0);
      tick();
      check("vec_step",       out[31:0], vecs[i].exp_step);
      check("vec_step_step0", step[0],   1'b1);
    end

    // ---- long sequence from seed 1 -----------------------------------------
    cfg_write(2'd0, 1'b1, 1'b0, 16'd0, 32'h1);
    tick(); check("long_1", out[31:0], 32'h8020_0003); check("long_1_step", step[0], 1'b1);
    tick(); check("long_2", out[31:0], 32'hC030_0002); check("long_2_step", step[0], 1'b1);
    tick(); check("long_3", out[31:0], 32'h6018_0001); check("long_3_step", step[0], 1'b1);

    // ---- short sequence and period on ch1 ----------------------------------
    cfg_write(2'd1, 1'b1, 1'b1, 16'd0, 32'h1);
    check("short_load", out[63:32], 32'h1);
    early = 1'b0;
    for (int k = 1; k <= 127; k++) begin
      tick();
      if (k <= 6) check("short_seq", out[63:32], short_seq[k-1]);
      else if (k < 127 && out[63:32] == 32'h1) early = 1'b1;
      if (k == 64) check("short_upper_zero", out[63:39], 25'd0);
    end
    check("short_period_127", out[63:32], 32'h1);
    check("short_no_early_repeat", early, 1'b0);

    // ---- divider on ch2 with an en pause -----------------------------------
    cfg_write(2'd2, 1'b1, 1'b0, 16'd3, 32'h5);
    act = 0;
    for (int t = 1; t <= 20; t++) begin
      en = (t >= 9 && t <= 13) ? 1'b0 : 1'b1;
      tick();
      if (en) act++;
      exp_bit = en && (act % 4 == 0);
      check("div3_step2", step[2], exp_bit);
    end
    en = 1'b1;

    // ---- write on an edge where ch2 is due ---------------------------------
    cfg_write(2'd2, 1'b1, 1'b0, 16'd3, 32'hABCD_0123);
    check("override_out",  out[95:64], 32'hABCD_0123);
    check("override_step", step[2],    1'b0);

    // ---- ch3 write: lands in the 4-channel instance, ignored by the other --
    en = 1'b0;
    cfg_write(2'd3, 1'b1, 1'b1, 16'd0, 32'h55);
    check("ch3_load", out[127:96], 32'h55);

    // ---- mix of four 0xFF bytes --------------------------------------------
    for (int c = 0; c < 4; c++) cfg_write(2'(c), 1'b1, 1'b0, 16'd0, 32'hFF);
    tick();
    check("mix_full",  mix,  10'd1020);
    check("mix3_full", mix3, 10'd765);

    // ---- random traffic ----------------------------------------------------
    for (int n = 0; n < 80; n++) begin
      en       = ($urandom_range(0, 3) != 0);
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_en   = ($urandom_range(0, 3) != 0);
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_div  = 16'($urandom_range(0, 3));
      cfg_seed = $urandom;
      tick();
    end
    cfg_we = 1'b0;
    en     = 1'b1;
    tick();

    // ---- asynchronous reset between edges ----------------------------------
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_out",  out,  {32'd4, 32'd3, 32'd2, 32'd1});
    check("async_step", step, 4'd0);
    check("async_mix",  mix,  10'd0);
    check("async_out3", out3, {32'd3, 32'd2, 32'd1});
    check("async_mix3", mix3, 10'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    cfg_write(2'd0, 1'b1, 1'b0, 16'd0, 32'h0);
    check("post_rst_load", out[31:0], 32'h1);
    tick();
    check("post_rst_step", out[31:0], 32'h8020_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_noise_lfsr_bank
